mul_arbiter: RTL and testbench

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_arbiter_pkg.sv | 20 ++
 rtl/mul_arbiter_if.sv | 29 ++
 rtl/mul_arbiter_rr.sv | 30 +++
 rtl/mul_arbiter.sv | 105 ++++++++++
 tb/tb_mul_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_arbiter_pkg.sv
// Shared types for the multiplier arbiter: FSM state, in-flight tag and an index-width helper.
package softmax_pkg;

  localparam int TAG_IDX_W = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
  } tag_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul_arbiter_if.sv
// Requester, multiplier and response signals shared by the arbiter and its environment.
interface mul_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 32
);
  // Handshake: requester i transfers on a rising edge where req_valid[i] && req_ready[i];
  // the requester may not depend on req_ready to raise req_valid. rsp_valid has no ready.
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_last;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic [NREQ-1:0]    req_ready;
  logic [DW-1:0]      mul_a;
  logic [DW-1:0]      mul_b;
  logic [DW-1:0]      mul_q;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_q;
  logic               busy;

  modport master (
    output req_valid, req_last, req_a, req_b, mul_q,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_q, busy
  );

  modport slave (
    input  req_valid, req_last, req_a, req_b, mul_q,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_q, busy
  );
endinterface

// File: rtl/mul_arbiter_rr.sv
// Round-robin priority picker: first asserted request at or above ptr, wrapping past N-1.
module rr_arbiter
  import softmax_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [idx_w(N)-1:0]   ptr,
  input  logic                  en,
  output logic [N-1:0]          gnt
);
  localparam int PW = idx_w(N);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int off = 0; off < N; off++) begin
      idx = PW'((int'(ptr) + off) % N);
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one external pipelined multiplier among NREQ requesters with burst locking
// and returns each result, tagged with its requester, MUL_LAT+1 cycles after accept.
module mul_arbiter
  import softmax_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DW      = 32,
  parameter int MUL_LAT = 2
) (
  input  logic                     clk,
  input  logic                     areset,
  mul_arbiter_if.slave             bus,
  output arb_state_e               state,
  output logic [idx_w(NREQ)-1:0]   ptr
);
  localparam int PW = idx_w(NREQ);

  logic [NREQ-1:0] rr_gnt;
  logic [NREQ-1:0] ready;
  logic [NREQ-1:0] fire;
  logic            accept;
  logic            last_g;
  logic [PW-1:0]   gidx;
  logic [PW-1:0]   owner;
  logic [DW-1:0]   op_a;
  logic [DW-1:0]   op_b;
  logic [DW-1:0]   mul_a_r;
  logic [DW-1:0]   mul_b_r;
  logic            inflight;
  tag_t            tag [MUL_LAT+1];

  rr_arbiter #(.N(NREQ)) u_rr (
    .req (bus.req_valid),
    .ptr (ptr),
    .en  (areset && (state == IDLE)),
    .gnt (rr_gnt)
  );

  // In LOCKED only the owner may transfer; its idle cycles leave the lock in place.
  always_comb begin
    ready = '0;
    if (areset) begin
      if (state == IDLE) ready = rr_gnt;
      else               ready[owner] = bus.req_valid[owner];
    end
  end

  assign fire   = bus.req_valid & ready;
  assign accept = |fire;
  assign last_g = |(fire & bus.req_last);

  always_comb begin
    gidx = '0;
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (fire[i]) begin
        gidx = PW'(i);
        op_a = bus.req_a[i*DW +: DW];
        op_b = bus.req_b[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state   <= IDLE;
      ptr     <= '0;
      owner   <= '0;
      mul_a_r <= '0;
      mul_b_r <= '0;
      for (int k = 0; k <= MUL_LAT; k++) tag[k] <= '0;
    end else begin
      if (accept) begin
        mul_a_r <= op_a;
        mul_b_r <= op_b;
        if (state == IDLE) begin
          ptr <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
          if (!last_g) begin
            state <= LOCKED;
            owner <= gidx;
          end
        end else if (last_g) begin
          state <= IDLE;
        end
      end
      // Tag stage k is valid in the cycle after edge t+k; stage MUL_LAT lines up with mul_q.
      tag[0] <= '{valid: accept, idx: TAG_IDX_W'(gidx)};
      for (int k = 1; k <= MUL_LAT; k++) tag[k] <= tag[k-1];
    end
  end

  always_comb begin
    inflight = 1'b0;
    for (int k = 0; k <= MUL_LAT; k++) inflight = inflight | tag[k].valid;
  end

  assign bus.req_ready = ready;
  assign bus.mul_a     = mul_a_r;
  assign bus.mul_b     = mul_b_r;
  assign bus.rsp_valid = tag[MUL_LAT].valid ? (NREQ'(1) << tag[MUL_LAT].idx) : '0;
  assign bus.rsp_q     = bus.mul_q;
  assign bus.busy      = inflight || (state == LOCKED);

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter with a behavioural single-precision multiplier pipeline.
module tb_mul_arbiter;
  import softmax_pkg::*;

  localparam int NREQ    = 4;
  localparam int DW      = 32;
  localparam int MUL_LAT = 2;

  localparam logic [31:0] F1   = 32'h3F800000;
  localparam logic [31:0] F2   = 32'h40000000;
  localparam logic [31:0] F3   = 32'h40400000;
  localparam logic [31:0] F4   = 32'h40800000;
  localparam logic [31:0] F6   = 32'h40C00000;
  localparam logic [31:0] F8   = 32'h41000000;
  localparam logic [31:0] FH   = 32'h3F000000;
  localparam logic [31:0] F15  = 32'h3FC00000;
  localparam logic [31:0] F225 = 32'h40100000;

  logic       clk    = 1'b0;
  logic       areset = 1'b0;
  arb_state_e state;
  logic [1:0] ptr;
  int         n_cmp  = 0;
  int         n_bad  = 0;
  logic [51:0] exp_q[$];
  logic [31:0] opa  [4] = '{F1, F2, F3, F4};
  logic [31:0] prod [4] = '{F2, F4, F6, F8};
  logic [31:0] mq   [MUL_LAT] = '{default: '0};

  mul_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus();

  mul_arbiter #(.NREQ(NREQ), .DW(DW), .MUL_LAT(MUL_LAT)) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus),
    .state  (state),
    .ptr    (ptr)
  );

  always #5 clk = ~clk;

  // Exact for normal operands whose product is representable; truncates otherwise.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    logic [22:0] m;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {a[31] ^ b[31], 31'd0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127 + 10'(p[47]);
    m = p[47] ? p[46:24] : p[45:23];
    return {a[31] ^ b[31], e[7:0], m};
  endfunction

  always @(posedge clk) begin
    mq[0] <= fmul(bus.mul_a, bus.mul_b);
    for (int k = 1; k < MUL_LAT; k++) mq[k] <= mq[k-1];
  end
  assign bus.mul_q = mq[MUL_LAT-1];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    areset = 1'b0;
    bus.req_valid = '1;
    bus.req_last  = '1;
    bus.req_a     = {4{F1}};
    bus.req_b     = {4{F2}};
    repeat (2) next_cycle();
    n_cmp++; if (bus.req_ready !== 4'b0) begin n_bad++; $display("FAIL reset_ready got %b want 0000", bus.req_ready); end
    n_cmp++; if (bus.mul_a !== 32'h0) begin n_bad++; $display("FAIL reset_mul_a got %h want 0", bus.mul_a); end
    n_cmp++; if (bus.mul_b !== 32'h0) begin n_bad++; $display("FAIL reset_mul_b got %h want 0", bus.mul_b); end
    n_cmp++; if (bus.rsp_valid !== 4'b0) begin n_bad++; $display("FAIL reset_rsp_valid got %b want 0000", bus.rsp_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_cmp++; if (state !== IDLE) begin n_bad++; $display("FAIL reset_state got %0d want IDLE", state); end
    n_cmp++; if (ptr !== 2'd0) begin n_bad++; $display("FAIL reset_ptr got %0d want 0", ptr); end
    bus.req_valid = '0;
    areset = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_ready;
    logic [51:0] e;
    bus.req_last = '1;
    for (int i = 0; i < 4; i++) begin
      bus.req_a[i*32 +: 32] = opa[i];
      bus.req_b[i*32 +: 32] = F2;
    end
    for (int s = 0; s < 8 + MUL_LAT + 1; s++) begin
      bus.req_valid = (s < 8) ? 4'hF : 4'h0;
      #1;
      exp_ready = (s < 8) ? 4'(1 << (s % 4)) : 4'b0;
      n_cmp++; if (bus.req_ready !== exp_ready) begin n_bad++; $display("FAIL rr_grant s=%0d got %b want %b", s, bus.req_ready, exp_ready); end
      if (exp_q.size() > 0 && exp_q[0][51:36] == 16'(s - MUL_LAT - 1)) begin
        e = exp_q.pop_front();
        n_cmp++; if (bus.rsp_valid !== e[35:32]) begin n_bad++; $display("FAIL rr_rsp_valid s=%0d got %b want %b", s, bus.rsp_valid, e[35:32]); end
        n_cmp++; if (bus.rsp_q !== e[31:0]) begin n_bad++; $display("FAIL rr_rsp_q s=%0d got %h want %h", s, bus.rsp_q, e[31:0]); end
      end else begin
        n_cmp++; if (bus.rsp_valid !== 4'b0) begin n_bad++; $display("FAIL rr_rsp_idle s=%0d got %b want 0000", s, bus.rsp_valid); end
      end
      if (s < 8) exp_q.push_back({16'(s), exp_ready, prod[s % 4]});
      next_cycle();
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rr_drain got %0d pending want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_wrap();
    n_cmp++; if (ptr !== 2'd0) begin n_bad++; $display("FAIL wrap_ptr_before got %0d want 0", ptr); end
    bus.req_valid = 4'b1000;
    bus.req_last  = 4'b1000;
    bus.req_a[96 +: 32] = F15;
    bus.req_b[96 +: 32] = F15;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b1000) begin n_bad++; $display("FAIL wrap_grant got %b want 1000", bus.req_ready); end
    next_cycle();
    bus.req_valid = '0;
    n_cmp++; if (ptr !== 2'd0) begin n_bad++; $display("FAIL wrap_ptr_after got %0d want 0", ptr); end
    n_cmp++; if (state !== IDLE) begin n_bad++; $display("FAIL wrap_state got %0d want IDLE", state); end
    repeat (MUL_LAT) next_cycle();
    n_cmp++; if (bus.rsp_valid !== 4'b1000) begin n_bad++; $display("FAIL wrap_rsp_valid got %b want 1000", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_q !== F225) begin n_bad++; $display("FAIL wrap_rsp_q got %h want %h", bus.rsp_q, F225); end
    next_cycle();
  endtask

  task automatic test_single();
    logic [3:0] exp_rsp;
    bus.req_valid = 4'b0001;
    bus.req_last  = 4'b0001;
    bus.req_a[0 +: 32] = F1;
    bus.req_b[0 +: 32] = F2;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_grant got %b want 0001", bus.req_ready); end
    next_cycle();
    bus.req_valid = '0;
    n_cmp++; if (bus.mul_a !== F1) begin n_bad++; $display("FAIL single_mul_a got %h want %h", bus.mul_a, F1); end
    n_cmp++; if (bus.mul_b !== F2) begin n_bad++; $display("FAIL single_mul_b got %h want %h", bus.mul_b, F2); end
    n_cmp++; if (ptr !== 2'd1) begin n_bad++; $display("FAIL single_ptr got %0d want 1", ptr); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL single_busy got %b want 1", bus.busy); end
    for (int k = 0; k <= MUL_LAT + 1; k++) begin
      exp_rsp = (k == MUL_LAT) ? 4'b0001 : 4'b0000;
      n_cmp++; if (bus.rsp_valid !== exp_rsp) begin n_bad++; $display("FAIL single_rsp_valid k=%0d got %b want %b", k, bus.rsp_valid, exp_rsp); end
      if (k == MUL_LAT) begin
        n_cmp++; if (bus.rsp_q !== F2) begin n_bad++; $display("FAIL single_rsp_q got %h want %h", bus.rsp_q, F2); end
      end
      next_cycle();
    end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_end got %b want 0", bus.busy); end
  endtask

  task automatic test_burst();
    logic [3:0]  exp_ready;
    logic [51:0] e;
    arb_state_e  exp_state;
    bus.req_a[64 +: 32] = F4;
    bus.req_b[64 +: 32] = FH;
    bus.req_b[32 +: 32] = F2;
    for (int s = 0; s < 4 + MUL_LAT + 1; s++) begin
      bus.req_valid = (s < 3) ? 4'b0110 : (s == 3) ? 4'b0100 : 4'b0000;
      bus.req_last  = (s == 2) ? 4'b0110 : 4'b0100;
      if (s < 3) bus.req_a[32 +: 32] = opa[s];
      #1;
      exp_ready = (s < 3) ? 4'b0010 : (s == 3) ? 4'b0100 : 4'b0000;
      exp_state = (s == 1 || s == 2) ? LOCKED : IDLE;
      n_cmp++; if (bus.req_ready !== exp_ready) begin n_bad++; $display("FAIL burst_grant s=%0d got %b want %b", s, bus.req_ready, exp_ready); end
      n_cmp++; if (state !== exp_state) begin n_bad++; $display("FAIL burst_state s=%0d got %0d want %0d", s, state, exp_state); end
      if (exp_q.size() > 0 && exp_q[0][51:36] == 16'(s - MUL_LAT - 1)) begin
        e = exp_q.pop_front();
        n_cmp++; if (bus.rsp_valid !== e[35:32]) begin n_bad++; $display("FAIL burst_rsp_valid s=%0d got %b want %b", s, bus.rsp_valid, e[35:32]); end
        n_cmp++; if (bus.rsp_q !== e[31:0]) begin n_bad++; $display("FAIL burst_rsp_q s=%0d got %h want %h", s, bus.rsp_q, e[31:0]); end
      end else begin
        n_cmp++; if (bus.rsp_valid !== 4'b0) begin n_bad++; $display("FAIL burst_rsp_idle s=%0d got %b want 0000", s, bus.rsp_valid); end
      end
      if (s < 4) exp_q.push_back({16'(s), exp_ready, (s < 3) ? prod[s] : F2});
      next_cycle();
    end
    n_cmp++; if (ptr !== 2'd3) begin n_bad++; $display("FAIL burst_ptr got %0d want 3", ptr); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL burst_drain got %0d pending want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_owner_idle();
    logic [3:0] exp_ready;
    arb_state_e exp_state;
    bus.req_a[0 +: 32] = F3;
    bus.req_b[0 +: 32] = F2;
    for (int s = 0; s < 6; s++) begin
      case (s)
        0:       begin bus.req_valid = 4'b0101; bus.req_last = 4'b0100; exp_ready = 4'b0001; end
        1, 2:    begin bus.req_valid = 4'b0100; bus.req_last = 4'b0100; exp_ready = 4'b0000; end
        3:       begin bus.req_valid = 4'b0101; bus.req_last = 4'b0101; exp_ready = 4'b0001; end
        4:       begin bus.req_valid = 4'b0100; bus.req_last = 4'b0100; exp_ready = 4'b0100; end
        default: begin bus.req_valid = 4'b0000; bus.req_last = 4'b0000; exp_ready = 4'b0000; end
      endcase
      #1;
      exp_state = (s >= 1 && s <= 3) ? LOCKED : IDLE;
      n_cmp++; if (bus.req_ready !== exp_ready) begin n_bad++; $display("FAIL idle_grant s=%0d got %b want %b", s, bus.req_ready, exp_ready); end
      n_cmp++; if (state !== exp_state) begin n_bad++; $display("FAIL idle_state s=%0d got %0d want %0d", s, state, exp_state); end
      next_cycle();
    end
    repeat (MUL_LAT + 1) next_cycle();
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy_end got %b want 0", bus.busy); end
    n_cmp++; if (ptr !== 2'd3) begin n_bad++; $display("FAIL idle_ptr got %0d want 3", ptr); end
  endtask

  task automatic test_reset_mid_op();
    logic [3:0] exp_rsp;
    bus.req_last  = 4'b1111;
    bus.req_valid = 4'b0010;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0010) begin n_bad++; $display("FAIL rst_op0_grant got %b want 0010", bus.req_ready); end
    next_cycle();
    bus.req_valid = 4'b0100;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0100) begin n_bad++; $display("FAIL rst_op1_grant got %b want 0100", bus.req_ready); end
    next_cycle();
    bus.req_valid = 4'b1111;
    areset = 1'b0;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0) begin n_bad++; $display("FAIL rst_mid_ready got %b want 0000", bus.req_ready); end
    n_cmp++; if (bus.mul_a !== 32'h0) begin n_bad++; $display("FAIL rst_mid_mul_a got %h want 0", bus.mul_a); end
    n_cmp++; if (bus.mul_b !== 32'h0) begin n_bad++; $display("FAIL rst_mid_mul_b got %h want 0", bus.mul_b); end
    n_cmp++; if (bus.rsp_valid !== 4'b0) begin n_bad++; $display("FAIL rst_mid_rsp_valid got %b want 0000", bus.rsp_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy got %b want 0", bus.busy); end
    n_cmp++; if (ptr !== 2'd0) begin n_bad++; $display("FAIL rst_mid_ptr got %0d want 0", ptr); end
    areset = 1'b1;
    bus.req_valid = 4'b0001;
    bus.req_last  = 4'b0001;
    bus.req_a[0 +: 32] = F3;
    bus.req_b[0 +: 32] = F2;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0001) begin n_bad++; $display("FAIL rst_release_grant got %b want 0001", bus.req_ready); end
    next_cycle();
    bus.req_valid = '0;
    n_cmp++; if (bus.mul_a !== F3) begin n_bad++; $display("FAIL rst_release_mul_a got %h want %h", bus.mul_a, F3); end
    n_cmp++; if (ptr !== 2'd1) begin n_bad++; $display("FAIL rst_release_ptr got %0d want 1", ptr); end
    for (int k = 0; k <= MUL_LAT; k++) begin
      exp_rsp = (k == MUL_LAT) ? 4'b0001 : 4'b0000;
      n_cmp++; if (bus.rsp_valid !== exp_rsp) begin n_bad++; $display("FAIL rst_after_rsp k=%0d got %b want %b", k, bus.rsp_valid, exp_rsp); end
      if (k == MUL_LAT) begin
        n_cmp++; if (bus.rsp_q !== F6) begin n_bad++; $display("FAIL rst_after_rsp_q got %h want %h", bus.rsp_q, F6); end
      end
      next_cycle();
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    test_reset();
    test_round_robin();
    test_wrap();
    test_single();
    test_burst();
    test_owner_idle();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
